// File: rtl/ldce_wr_seq_if.sv
// ldce_wr_seq_if: request and latch-bank bus of the LDCE write sequencer.
//   S_VALID/S_READY/S_ADDR/S_DATA : word write request handshake
//   FLUSH                         : request to clear the whole latch bank
//   LD_D/LD_G/LD_GE/LD_CLR        : latch bank data, one-hot gate, gate enable, clear
//   DONE/ERR                      : completion pulse, out-of-range address pulse
// master = requester / observer side, slave = the sequencer.
interface ldce_wr_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
);
  logic              S_VALID;
  logic              S_READY;
  logic [ADDR_W-1:0] S_ADDR;
  logic [DATA_W-1:0] S_DATA;
  logic              FLUSH;
  logic [DATA_W-1:0] LD_D;
  logic [DEPTH-1:0]  LD_G;
  logic              LD_GE;
  logic              LD_CLR;
  logic              DONE;
  logic              ERR;

  modport master (
    output S_VALID, S_ADDR, S_DATA, FLUSH,
    input  S_READY, LD_D, LD_G, LD_GE, LD_CLR, DONE, ERR
  );

  modport slave (
    input  S_VALID, S_ADDR, S_DATA, FLUSH,
    output S_READY, LD_D, LD_G, LD_GE, LD_CLR, DONE, ERR
  );
endinterface

// File: rtl/ldce_wr_seq.sv
// ldce_wr_seq: write sequencer for a bank of LDCE latches.
//   C   : clock, rising edge
//   CLR : asynchronous clear, active high (also clears the latch bank)
//   bus : ldce_wr_seq_if slave port (request handshake + latch bank drive)
// Each accepted write runs SETUP -> PULSE -> HOLD so D is stable around the
// gate pulse; FLUSH pulses LD_CLR for PULSE_CYC cycles. All bank-side
// outputs are registered; only S_READY is combinational (state and CLR).
module ldce_wr_seq #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input logic         C,
  input logic         CLR,
  ldce_wr_seq_if.slave bus
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, FLUSHING} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] ld_d, ld_d_nx;
  logic [DEPTH-1:0]  ld_g, ld_g_nx;
  logic              ld_ge, ld_ge_nx;
  logic              ld_clr, ld_clr_nx;
  logic              done, done_nx;
  logic              err, err_nx;
  logic              s_ready;
  logic              in_range;

  assign s_ready  = (state == IDLE) & ~CLR;
  // DEPTH <= 2**ADDR_W, so one extra bit always holds DEPTH.
  assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));

  // cnt counts down the remaining cycles of the current phase; a phase
  // ends on the edge where cnt is 0.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    addr_nx   = addr_q;
    ld_d_nx   = ld_d;
    ld_g_nx   = '0;
    ld_ge_nx  = 1'b0;
    ld_clr_nx = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.FLUSH) begin
          state_nx  = FLUSHING;
          cnt_nx    = CNT_W'(PULSE_CYC - 1);
          ld_clr_nx = 1'b1;
        end else if (bus.S_VALID && s_ready) begin
          state_nx = SETUP;
          cnt_nx   = CNT_W'(SETUP_CYC - 1);
          addr_nx  = bus.S_ADDR;
          ld_d_nx  = bus.S_DATA;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = PULSE;
          cnt_nx   = CNT_W'(PULSE_CYC - 1);
          if (in_range) begin
            ld_g_nx  = DEPTH'(1) << addr_q;
            ld_ge_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nx   = cnt - 1'b1;
          ld_g_nx  = ld_g;
          ld_ge_nx = ld_ge;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      FLUSHING: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx    = cnt - 1'b1;
          ld_clr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // LD_CLR resets to 1 so the bank is cleared until the first edge after CLR.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      ld_d   <= '0;
      ld_g   <= '0;
      ld_ge  <= 1'b0;
      ld_clr <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      ld_d   <= ld_d_nx;
      ld_g   <= ld_g_nx;
      ld_ge  <= ld_ge_nx;
      ld_clr <= ld_clr_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.LD_D    = ld_d;
  assign bus.LD_G    = ld_g;
  assign bus.LD_GE   = ld_ge;
  assign bus.LD_CLR  = ld_clr;
  assign bus.DONE    = done;
  assign bus.ERR     = err;

endmodule

// File: tb/tb_ldce_wr_seq.sv
// tb_ldce_wr_seq: directed bench for ldce_wr_seq.
//   u0 : default parameters (cycle table: write, flush vs write, ignored request, CLR abort)
//   u1 : SETUP=2 PULSE=3 HOLD=2, back-to-back writes
//   u2 : DEPTH=6, out-of-range and top in-range address
module tb_ldce_wr_seq;
  logic C;
  logic CLR;
  int   n_cmp;
  int   n_err;

  ldce_wr_seq_if #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) if0 ();
  ldce_wr_seq_if #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) if1 ();
  ldce_wr_seq_if #(.DATA_W(8), .ADDR_W(3), .DEPTH(6)) if2 ();

  ldce_wr_seq #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
    u0 (.C(C), .CLR(CLR), .bus(if0.slave));
  ldce_wr_seq #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2))
    u1 (.C(C), .CLR(CLR), .bus(if1.slave));
  ldce_wr_seq #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1))
    u2 (.C(C), .CLR(CLR), .bus(if2.slave));

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       f;
    logic       rdy;
    logic [7:0] ld_d;
    logic [7:0] g;
    logic       ge;
    logic       clr;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(logic v, logic [2:0] a, logic [7:0] d, logic f, logic rdy,
                              logic [7:0] ld_d, logic [7:0] g, logic ge, logic clr,
                              logic done, logic err);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.f = f; r.rdy = rdy; r.ld_d = ld_d; r.g = g;
    r.ge = ge; r.clr = clr; r.done = done; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge C);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    CLR = 1'b1;
    if0.S_VALID = 0; if0.S_ADDR = 0; if0.S_DATA = 0; if0.FLUSH = 0;
    if1.S_VALID = 0; if1.S_ADDR = 0; if1.S_DATA = 0; if1.FLUSH = 0;
    if2.S_VALID = 0; if2.S_ADDR = 0; if2.S_DATA = 0; if2.FLUSH = 0;

    //             v  a  d      f  rdy ld_d   g      ge clr done err
    vt[0]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0); // just released
    vt[1]  = mk(1, 5, 8'hA5, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0); // write 5 <- A5
    vt[2]  = mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 0); // SETUP
    vt[3]  = mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h20, 1, 0, 0, 0); // PULSE
    vt[4]  = mk(0, 0, 8'h00, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 0); // HOLD
    vt[5]  = mk(1, 3, 8'h3C, 1, 1, 8'hA5, 8'h00, 0, 0, 1, 0); // DONE; flush beats write
    vt[6]  = mk(1, 3, 8'h3C, 0, 0, 8'hA5, 8'h00, 0, 1, 0, 0); // FLUSHING
    vt[7]  = mk(1, 3, 8'h3C, 0, 1, 8'hA5, 8'h00, 0, 0, 1, 0); // DONE; write accepted
    vt[8]  = mk(0, 0, 8'h00, 0, 0, 8'h3C, 8'h00, 0, 0, 0, 0); // SETUP
    vt[9]  = mk(1, 1, 8'h99, 0, 0, 8'h3C, 8'h08, 1, 0, 0, 0); // PULSE; request ignored
    vt[10] = mk(0, 0, 8'h00, 0, 0, 8'h3C, 8'h00, 0, 0, 0, 0); // HOLD
    vt[11] = mk(0, 0, 8'h00, 0, 1, 8'h3C, 8'h00, 0, 0, 1, 0); // DONE
    vt[12] = mk(0, 0, 8'h00, 0, 1, 8'h3C, 8'h00, 0, 0, 0, 0); // nothing queued

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d clr", i),   32'(if0.LD_CLR), 32'd1);
      chk($sformatf("rst%0d rdy", i),   32'(if0.S_READY), 32'd0);
      chk($sformatf("rst%0d d", i),     32'(if0.LD_D), 32'd0);
      chk($sformatf("rst%0d g", i),     32'(if0.LD_G), 32'd0);
      chk($sformatf("rst%0d ge", i),    32'(if0.LD_GE), 32'd0);
      chk($sformatf("rst%0d done", i),  32'(if0.DONE), 32'd0);
      chk($sformatf("rst%0d err", i),   32'(if0.ERR), 32'd0);
      chk($sformatf("rst%0d clr2", i),  32'(if2.LD_CLR), 32'd1);
    end
    @(negedge C);
    CLR = 1'b0;
    #1;

    // u0 cycle table
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("t%0d rdy", i),  32'(if0.S_READY), 32'(vt[i].rdy));
      chk($sformatf("t%0d d", i),    32'(if0.LD_D),    32'(vt[i].ld_d));
      chk($sformatf("t%0d g", i),    32'(if0.LD_G),    32'(vt[i].g));
      chk($sformatf("t%0d ge", i),   32'(if0.LD_GE),   32'(vt[i].ge));
      chk($sformatf("t%0d clr", i),  32'(if0.LD_CLR),  32'(vt[i].clr));
      chk($sformatf("t%0d done", i), 32'(if0.DONE),    32'(vt[i].done));
      chk($sformatf("t%0d err", i),  32'(if0.ERR),     32'(vt[i].err));
      if0.S_VALID = vt[i].v;
      if0.S_ADDR  = vt[i].a;
      if0.S_DATA  = vt[i].d;
      if0.FLUSH   = vt[i].f;
      step();
    end

    // u1 back-to-back writes, S_VALID held through the first DONE
    for (int k = 0; k < 18; k++) begin
      logic [7:0] eg, ed;
      logic       er, edn;
      eg  = (k >= 3 && k <= 5) ? 8'h01 : (k >= 11 && k <= 13) ? 8'h80 : 8'h00;
      ed  = (k == 0) ? 8'h00 : (k <= 8) ? 8'h11 : 8'h77;
      er  = (k == 0) || (k == 8) || (k >= 16);
      edn = (k == 8) || (k == 16);
      chk($sformatf("b2b%0d g", k),    32'(if1.LD_G), 32'(eg));
      chk($sformatf("b2b%0d ge", k),   32'(if1.LD_GE), 32'(eg != 8'h00));
      chk($sformatf("b2b%0d d", k),    32'(if1.LD_D), 32'(ed));
      chk($sformatf("b2b%0d rdy", k),  32'(if1.S_READY), 32'(er));
      chk($sformatf("b2b%0d done", k), 32'(if1.DONE), 32'(edn));
      if (k == 0) begin
        if1.S_VALID = 1; if1.S_ADDR = 3'd0; if1.S_DATA = 8'h11;
      end else if (k <= 8) begin
        if1.S_VALID = 1; if1.S_ADDR = 3'd7; if1.S_DATA = 8'h77;
      end else begin
        if1.S_VALID = 0; if1.S_ADDR = 3'd0; if1.S_DATA = 8'h00;
      end
      step();
    end

    // u2 DEPTH=6: address 6 is out of range, address 5 is the top word
    for (int k = 0; k < 9; k++) begin
      logic [7:0] ed;
      ed = (k == 0) ? 8'h00 : (k <= 4) ? 8'h5A : 8'h01;
      chk($sformatf("oor%0d err", k),  32'(if2.ERR), 32'(k == 2));
      chk($sformatf("oor%0d g", k),    32'(if2.LD_G), (k == 6) ? 32'h20 : 32'h0);
      chk($sformatf("oor%0d ge", k),   32'(if2.LD_GE), 32'(k == 6));
      chk($sformatf("oor%0d done", k), 32'(if2.DONE), 32'((k == 4) || (k == 8)));
      chk($sformatf("oor%0d rdy", k),  32'(if2.S_READY), 32'((k == 0) || (k == 4) || (k == 8)));
      chk($sformatf("oor%0d d", k),    32'(if2.LD_D), 32'(ed));
      if2.S_VALID = (k == 0) || (k == 4);
      if2.S_ADDR  = (k == 0) ? 3'd6 : 3'd5;
      if2.S_DATA  = (k == 0) ? 8'h5A : 8'h01;
      step();
    end

    // u0 CLR during PULSE of a write to address 2
    if0.S_VALID = 1; if0.S_ADDR = 3'd2; if0.S_DATA = 8'h42;
    step();
    if0.S_VALID = 0;
    chk("abort setup d", 32'(if0.LD_D), 32'h42);
    step();
    chk("abort pulse g", 32'(if0.LD_G), 32'h04);
    chk("abort pulse ge", 32'(if0.LD_GE), 32'd1);
    #1;
    CLR = 1'b1;
    #1;
    chk("abort g", 32'(if0.LD_G), 32'd0);
    chk("abort ge", 32'(if0.LD_GE), 32'd0);
    chk("abort clr", 32'(if0.LD_CLR), 32'd1);
    chk("abort rdy", 32'(if0.S_READY), 32'd0);
    step();
    step();
    CLR = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort%0d done", k), 32'(if0.DONE), 32'd0);
      chk($sformatf("abort%0d clr", k), 32'(if0.LD_CLR), 32'(k == 0));
      chk($sformatf("abort%0d rdy", k), 32'(if0.S_READY), 32'd1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
